// File: rtl/pixel_buffer_if.sv
// pixel_buffer_if -- request/read bundle for the pixel_buffer drawing engine.
//
// Signals (directions as seen by the engine, modport slave):
//   brush      in   stamp request, accepted only while ready=1
//   clear      in   full-screen clear request, wins over brush
//   wx, wy     in   stamp center column / row
//   brushSize  in   stamp radius r
//   newColor   in   stamp color
//   rx, ry     in   read column / row, sampled every cycle
//   ready      out  engine idle and accepting requests
//   colorCode  out  registered read data (one cycle after rx/ry)
// The master modport is the mirror image, for whatever drives the engine.
interface pixel_buffer_if #(
    parameter int XW = 8,
    parameter int YW = 8,
    parameter int CW = 3,
    parameter int SW = 3
) ();
    logic          brush;
    logic          clear;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic [SW-1:0] brushSize;
    logic [CW-1:0] newColor;
    logic [XW-1:0] rx;
    logic [YW-1:0] ry;
    logic          ready;
    logic [CW-1:0] colorCode;

    modport master (
        output brush, clear, wx, wy, brushSize, newColor, rx, ry,
        input  ready, colorCode
    );

    modport slave (
        input  brush, clear, wx, wy, brushSize, newColor, rx, ry,
        output ready, colorCode
    );
endinterface

// File: rtl/pixel_buffer.sv
// pixel_buffer -- frame store with a square-brush stamp engine and a
// full-screen clear engine.
//
// Ports:
//   clk      sole clock, all state on the rising edge
//   reset_n  asynchronous active-low reset; forces the engine into CLEAR,
//            so every release is followed by a full-screen clear
//   bus      pixel_buffer_if.slave: brush/clear requests with stamp
//            parameters, independent read port rx/ry -> colorCode,
//            ready high only while idle
//
// Storage is 2**(XW+YW) words of CW bits addressed {y,x}. The read port
// runs every cycle regardless of engine state and returns the pre-write
// value on a same-address collision. Reads outside the visible frame
// return BG.
module pixel_buffer #(
    parameter int WIDTH  = 200,
    parameter int HEIGHT = 200,
    parameter int XW     = 8,
    parameter int YW     = 8,
    parameter int CW     = 3,
    parameter int SW     = 3,
    parameter int BG     = 0
) (
    input logic          clk,
    input logic          reset_n,
    pixel_buffer_if.slave bus
);
    // Signed coordinate width: wide enough that center +/- radius never wraps.
    localparam int MXY = (XW > YW) ? XW : YW;
    localparam int CIW = ((MXY > SW) ? MXY : SW) + 2;

    typedef logic signed [CIW-1:0] coord_t;
    typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

    localparam coord_t        X_LAST = coord_t'(WIDTH - 1);
    localparam coord_t        Y_LAST = coord_t'(HEIGHT - 1);
    localparam logic [XW:0]   X_LIM  = (XW + 1)'(WIDTH);
    localparam logic [YW:0]   Y_LIM  = (YW + 1)'(HEIGHT);
    localparam logic [CW-1:0] BG_C   = CW'(BG);

    function automatic logic in_frame(input coord_t x, input coord_t y);
        return !x[CIW-1] && (x <= X_LAST) && !y[CIW-1] && (y <= Y_LAST);
    endfunction

    logic [CW-1:0] mem [2**(XW+YW)];

    state_t        state;
    logic          ready_q;
    coord_t        px, py;          // pixel visited this cycle
    coord_t        x_lo, x_hi;      // column span of the current walk
    coord_t        y_hi;            // last row of the current walk
    logic [CW-1:0] pen;             // color written by the current walk

    coord_t cx_req, cy_req, r_req;
    assign cx_req = $signed({{(CIW-XW){1'b0}}, bus.wx});
    assign cy_req = $signed({{(CIW-YW){1'b0}}, bus.wy});
    assign r_req  = $signed({{(CIW-SW){1'b0}}, bus.brushSize});

    // Stamp and clear share one row-major rectangle walker: a stamp walks
    // the (2r+1)^2 box around its center, a clear walks the visible frame.
    // Every visited pixel costs one cycle; only in-frame ones are written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            ready_q <= 1'b0;
            px      <= '0;
            py      <= '0;
            x_lo    <= '0;
            x_hi    <= X_LAST;
            y_hi    <= Y_LAST;
            pen     <= BG_C;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clear) begin
                        state   <= CLEAR;
                        ready_q <= 1'b0;
                        px      <= '0;
                        py      <= '0;
                        x_lo    <= '0;
                        x_hi    <= X_LAST;
                        y_hi    <= Y_LAST;
                        pen     <= BG_C;
                    end else if (bus.brush) begin
                        state   <= STAMP;
                        ready_q <= 1'b0;
                        px      <= cx_req - r_req;
                        py      <= cy_req - r_req;
                        x_lo    <= cx_req - r_req;
                        x_hi    <= cx_req + r_req;
                        y_hi    <= cy_req + r_req;
                        pen     <= bus.newColor;
                    end
                end
                default: begin
                    if (px == x_hi) begin
                        px <= x_lo;
                        if (py == y_hi) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            py <= py + coord_t'(1);
                        end
                    end else begin
                        px <= px + coord_t'(1);
                    end
                end
            endcase
        end
    end

    // Write port: gated by reset_n so a held reset never writes memory.
    logic                wr_en_p0;
    logic [XW+YW-1:0]    wr_addr_p0;
    assign wr_en_p0   = reset_n && (state != IDLE) && in_frame(px, py);
    assign wr_addr_p0 = {py[YW-1:0], px[XW-1:0]};

    always_ff @(posedge clk) begin
        if (wr_en_p0) begin
            mem[wr_addr_p0] <= pen;
        end
    end

    // Read port: registered, one cycle latency, out-of-frame reads give BG.
    logic             rd_in_p0;
    logic [XW+YW-1:0] rd_addr_p0;
    logic [CW-1:0]    color_p1;
    assign rd_in_p0   = ({1'b0, bus.rx} < X_LIM) && ({1'b0, bus.ry} < Y_LIM);
    assign rd_addr_p0 = {bus.ry, bus.rx};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            color_p1 <= '0;
        end else begin
            color_p1 <= rd_in_p0 ? mem[rd_addr_p0] : BG_C;
        end
    end

    assign bus.colorCode = color_p1;
    assign bus.ready     = ready_q;
endmodule

// File: tb/tb_pixel_buffer.sv
// tb_pixel_buffer -- randomized scoreboard bench for pixel_buffer.
// A reduced frame (64x48, BG=2) keeps every full clear short; the column
// count equals 2**XW so any coordinate wrap would land on a visible pixel.
module tb_pixel_buffer;
    localparam int W  = 64;
    localparam int H  = 48;
    localparam int XW = 6;
    localparam int YW = 6;
    localparam int CW = 3;
    localparam int SW = 3;
    localparam int BG = 2;
    localparam int LIMIT = W * H + 100;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pixel_buffer_if #(.XW(XW), .YW(YW), .CW(CW), .SW(SW)) bus ();

    pixel_buffer #(
        .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .CW(CW), .SW(SW), .BG(BG)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input int got, input int want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    // Reference frame: what each visible pixel should hold.
    int ref_mem [H][W];

    function automatic int ref_rd(input int x, input int y);
        if (x >= W || y >= H) return BG;
        return ref_mem[y][x];
    endfunction

    task automatic model_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                ref_mem[y][x] = BG;
    endtask

    task automatic model_stamp(input int cx, input int cy, input int r, input int c);
        for (int y = cy - r; y <= cy + r; y++)
            for (int x = cx - r; x <= cx + r; x++)
                if (x >= 0 && x < W && y >= 0 && y < H) ref_mem[y][x] = c;
    endtask

    // Scoreboard: stimulus pushes, monitor pops one cycle later.
    typedef struct { int x; int y; int exp; } rd_t;
    rd_t sbq[$];
    rd_t e;
    bit  rd_flag = 1'b0;
    bit  rd_pend = 1'b0;

    always @(posedge clk) rd_pend <= rd_flag;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (sbq.size() == 0) begin
                chk(1'b0, "scoreboard_underflow", 0, 1);
            end else begin
                e = sbq.pop_front();
                chk(int'(bus.colorCode) == e.exp,
                    $sformatf("read(%0d,%0d)", e.x, e.y), int'(bus.colorCode), e.exp);
            end
        end
    end

    task automatic read_px(input int x, input int y, input int exp);
        rd_t t;
        t.x = x; t.y = y; t.exp = exp;
        bus.rx = XW'(x);
        bus.ry = YW'(y);
        rd_flag = 1'b1;
        sbq.push_back(t);
        @(negedge clk);
        rd_flag = 1'b0;
    endtask

    task automatic read_model(input int x, input int y);
        read_px(x, y, ref_rd(x, y));
    endtask

    // Counts negedges until ready; brush is pulsed once at cycle pulse_at.
    task automatic wait_ready(output int cnt, input int pulse_at);
        cnt = 0;
        while (!bus.ready && cnt < LIMIT) begin
            bus.brush = (cnt == pulse_at);
            @(negedge clk);
            cnt++;
        end
        bus.brush = 1'b0;
    endtask

    task automatic issue_stamp(input int x, input int y, input int r, input int c);
        bus.wx = XW'(x);
        bus.wy = YW'(y);
        bus.brushSize = SW'(r);
        bus.newColor = CW'(c);
        bus.brush = 1'b1;
        @(negedge clk);
        bus.brush = 1'b0;
        // Scramble inputs: the captured request must not notice.
        bus.wx = XW'($urandom);
        bus.wy = YW'($urandom);
        bus.brushSize = SW'($urandom);
        bus.newColor = CW'($urandom);
    endtask

    task automatic stamp(input int x, input int y, input int r, input int c, input bit intr);
        int cnt;
        issue_stamp(x, y, r, c);
        wait_ready(cnt, intr ? 0 : -1);
        chk(cnt == (2*r+1)*(2*r+1), $sformatf("stamp_busy(r=%0d)", r), cnt, (2*r+1)*(2*r+1));
        model_stamp(x, y, r, c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, old;
        reset_n = 1'b0;
        bus.brush = 1'b0; bus.clear = 1'b0;
        bus.wx = '0; bus.wy = '0; bus.brushSize = '0; bus.newColor = '0;
        bus.rx = '0; bus.ry = '0;
        repeat (2) @(negedge clk);
        chk(bus.colorCode == '0, "reset_colorCode", int'(bus.colorCode), 0);
        chk(bus.ready == 1'b0, "reset_ready", int'(bus.ready), 0);

        // Post-reset clear.
        reset_n = 1'b1;
        wait_ready(cnt, -1);
        chk(cnt == W*H, "init_clear_busy", cnt, W*H);
        model_clear();
        read_px(0, 0, BG);
        read_px(W-1, H-1, BG);
        read_px(5, H, BG);
        read_px(5, 63, BG);

        // 3x3 stamp.
        stamp(10, 20, 1, 5, 1'b0);
        for (int y = 19; y <= 21; y++)
            for (int x = 9; x <= 11; x++)
                read_px(x, y, 5);
        read_px(12, 20, BG);
        read_px(10, 22, BG);

        // Edge stamps: clipped, no wrap (column W-1 is 2**XW-1).
        stamp(0, H-1, 2, 3, 1'b0);
        for (int y = H-3; y < H; y++)
            for (int x = 0; x <= 2; x++)
                read_px(x, y, 3);
        read_px(W-1, H-1, BG);
        read_px(W-2, H-2, BG);
        read_px(0, 0, BG);
        stamp(W-1, 0, 2, 6, 1'b1);
        read_px(W-1, 0, 6);
        read_px(W-3, 2, 6);
        read_px(0, 0, BG);
        read_px(1, 1, BG);
        read_px(0, H-1, 3);

        // Read/write collision on (10,20): its write is the 5th stamp cycle.
        old = ref_rd(10, 20);
        issue_stamp(10, 20, 1, 6);
        repeat (4) @(negedge clk);
        read_px(10, 20, old);
        read_px(10, 20, 6);
        wait_ready(cnt, -1);
        chk(cnt == 3, "collision_stamp_tail", cnt, 3);
        model_stamp(10, 20, 1, 6);
        read_model(9, 19);

        // Random stamps, some with an ignored mid-stamp brush pulse.
        for (int i = 0; i < 10; i++) begin
            stamp($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 7),
                  $urandom_range(0, 7), 1'($urandom));
            for (int k = 0; k < 6; k++)
                read_model($urandom_range(0, 63), $urandom_range(0, 63));
        end
        for (int k = 0; k < 20; k++)
            read_model($urandom_range(0, 63), $urandom_range(0, 63));

        // brush+clear together: clear wins; a brush during the clear is dropped.
        bus.wx = 6'd5; bus.wy = 6'd5; bus.brushSize = 3'd0; bus.newColor = 3'd7;
        bus.brush = 1'b1; bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        wait_ready(cnt, 100);
        chk(cnt == W*H, "clear_busy", cnt, W*H);
        model_clear();
        read_px(5, 5, BG);
        read_px(10, 20, BG);
        read_px(0, H-1, BG);
        read_px(W-1, 0, BG);

        // Reset four cycles into an r=3 stamp.
        issue_stamp(20, 20, 3, 7);
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk(bus.colorCode == '0, "async_reset_colorCode", int'(bus.colorCode), 0);
        chk(bus.ready == 1'b0, "async_reset_ready", int'(bus.ready), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_ready(cnt, -1);
        chk(cnt == W*H, "reset_clear_busy", cnt, W*H);
        model_clear();
        for (int d = -3; d <= 3; d++) begin
            read_px(20 + d, 17, BG);
            read_px(20 + d, 20 + d, BG);
        end
        for (int k = 0; k < 8; k++)
            read_model($urandom_range(0, 63), $urandom_range(0, 63));

        repeat (3) @(negedge clk);
        chk(sbq.size() == 0, "scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pixel_buffer.md
PIXEL_BUFFER -- requirements
Module: pixel_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 200, meaning visible columns.
REQ-002 SHALL have parameter HEIGHT, default 200, meaning visible rows.
REQ-003 SHALL have parameter XW, default 8, meaning column-coordinate bits (2**XW >= WIDTH).
REQ-004 SHALL have parameter YW, default 8, meaning row-coordinate bits (2**YW >= HEIGHT).
REQ-005 SHALL have parameter CW, default 3, meaning color-code bits.
REQ-006 SHALL have parameter SW, default 3, meaning brush-radius bits.
REQ-007 SHALL have parameter BG, default 0, meaning background/clear color.
REQ-008 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-009 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-010 SHALL have port brush  input  1  stamp request.
REQ-011 SHALL have port clear  input  1  full-screen clear request.
REQ-012 SHALL have port wx  input  XW  stamp center column.
REQ-013 SHALL have port wy  input  YW  stamp center row.
REQ-014 SHALL have port brushSize  input  SW  stamp radius r.
REQ-015 SHALL have port newColor  input  CW  stamp color.
REQ-016 SHALL have port rx  input  XW  read column.
REQ-017 SHALL have port ry  input  YW  read row.
REQ-018 SHALL have port ready  output  1  engine idle, accepting requests.
REQ-019 SHALL have port colorCode  output  CW  registered read data.

Function
REQ-020 Storage SHALL be 2**(XW+YW) entries of CW bits, addressed {y,x}; one write port, one independent read port.
REQ-021 Read SHALL have 1-cycle latency: colorCode at edge N+1 reflects rx/ry sampled at edge N, every cycle, regardless of engine state.
REQ-022 Read with rx >= WIDTH or ry >= HEIGHT SHALL return BG.
REQ-023 Read and write to the same address in the same cycle SHALL return the pre-write value.
REQ-024 FSM states SHALL be IDLE, STAMP, CLEAR; ready = 1 only in IDLE.
REQ-025 Request accepted on an edge where ready=1 and brush or clear=1; clear SHALL take priority when both asserted.
REQ-026 On stamp acceptance, wx, wy, brushSize, newColor SHALL be captured; later input changes have no effect on that stamp.
REQ-027 STAMP SHALL visit offsets dy = -r..+r (outer), dx = -r..+r (inner), row-major, one pixel per cycle, exactly (2r+1)**2 cycles, then return to IDLE.
REQ-028 Coordinate arithmetic SHALL be signed, at least max(XW,YW)+2 bits; no wrap-around.
REQ-029 Visited pixels with x<0, x>=WIDTH, y<0 or y>=HEIGHT SHALL NOT be written but still consume their cycle.
REQ-030 r=0 SHALL write only the center pixel, 1 cycle in STAMP.
REQ-031 CLEAR SHALL write BG to every x<WIDTH, y<HEIGHT, one pixel per cycle, row-major from (0,0), exactly WIDTH*HEIGHT cycles, then IDLE.
REQ-032 Requests asserted while ready=0 SHALL be ignored (not queued).
REQ-033 ready SHALL rise on the edge after the final write of a STAMP or CLEAR; a new request may be accepted on the cycle ready is first 1.

Reset
REQ-034 reset_n=0 SHALL immediately force colorCode=0, internal counters to 0 and FSM to CLEAR (ready=0), independent of clk.
REQ-035 On reset_n release the block SHALL perform a full CLEAR (REQ-031) before entering IDLE.
REQ-036 Reset asserted mid-STAMP or mid-CLEAR SHALL abandon the operation; no further writes of it occur.
REQ-037 Memory contents SHALL NOT be reset asynchronously; only the post-reset CLEAR initialises them.

Verification
REQ-038 Release reset -> ready=0 for exactly 40000 cycles, then 1; reading (0,0), (199,199) gives 0; reading (200,5) gives BG.
REQ-039 Stamp wx=10, wy=20, r=1, color=5 -> ready low 9 cycles; (9..11,19..21) read 5, (12,20) reads 0.
REQ-040 Stamp wx=0, wy=199, r=2, color=3 -> ready low 25 cycles; only in-range pixels (0..2,197..199) read 3; nothing wraps to column 255 or row 0.
REQ-041 brush and clear asserted together when ready=1 -> CLEAR runs (40000 cycles); a second brush pulse during CLEAR produces no write.
REQ-042 Reset pulse at cycle 4 of a r=3 stamp -> stamp abandoned, full CLEAR follows, all pixels read BG afterward.
REQ-043 Same-cycle read and write of (10,20) during stamp -> colorCode shows old value next cycle, new value on the following read.
